// File: rtl/count_unit.sv
// count_unit: two-stage CLZ / CTZ / CPOP unit carrying an opaque tag with each operation.
// Latency: a result is presented 2 cycles after acceptance; one operation per cycle sustained.
// Backpressure: valid/ready on both sides; in_ready is low while flush is high or when both stages are held.
module count_unit #(
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;

  // S1: operand register (operand already bit-reversed for CTZ)
  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [31:0]      s1_dat_q, s1_dat_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // S2: result register
  logic             s2_vld_q, s2_vld_d;
  logic [5:0]       s2_cnt_q, s2_cnt_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic out_hs;
  logic s2_adv;
  logic accept;
  logic [5:0] s1_result;

  // Leading-zero count of a 32-bit word; 32 for an all-zero word.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    logic       seen;
    n    = 6'd0;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!seen) begin
        if (v[i]) seen = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  // Number of set bits in a 32-bit word.
  function automatic logic [5:0] pop32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Mirror bit order so CTZ can reuse the leading-zero counter.
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Handshake decisions; in_ready never depends on in_valid/in_data, only on state, out_ready and flush.
  always_comb begin
    out_hs   = s2_vld_q && out_ready;
    s2_adv   = s1_vld_q && (!s2_vld_q || out_ready);
    in_ready = !flush && (!s1_vld_q || s2_adv);
    accept   = in_valid && in_ready;
  end

  // Count computed from the registered S1 operand only.
  always_comb begin
    s1_result = 6'd0;
    case (s1_op_q)
      OP_CLZ, OP_CTZ: s1_result = lzc32(s1_dat_q);
      OP_CPOP:        s1_result = pop32(s1_dat_q);
      default:        s1_result = 6'd0;
    endcase
  end

  // Next-state for both stages; flush overrides any advance or acceptance.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_dat_d = s1_dat_q;
    s1_tag_d = s1_tag_q;
    s2_vld_d = s2_vld_q;
    s2_cnt_d = s2_cnt_q;
    s2_tag_d = s2_tag_q;

    if (out_hs) s2_vld_d = 1'b0;
    if (s2_adv) begin
      s2_vld_d = 1'b1;
      s2_cnt_d = s1_result;
      s2_tag_d = s1_tag_q;
      s1_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_op_d  = in_op;
      s1_dat_d = (in_op == OP_CTZ) ? rev32(in_data) : in_data;
      s1_tag_d = in_tag;
    end
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  // Stage valid bits; reset wins over flush and new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // Stage payloads; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    s1_op_q  <= s1_op_d;
    s1_dat_q <= s1_dat_d;
    s1_tag_q <= s1_tag_d;
    s2_cnt_q <= s2_cnt_d;
    s2_tag_q <= s2_tag_d;
  end

  assign out_valid = s2_vld_q;
  assign out_data  = {26'd0, s2_cnt_q};
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_count_unit.sv
// Directed bench for count_unit with a scoreboard of expected results.
// Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.
module tb_count_unit;

  localparam int TAG_W = 7;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  count_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [31:0]      dat;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic             prev_stall = 1'b0;
  logic [31:0]      prev_data;
  logic [TAG_W-1:0] prev_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference counts, written independently of any bit reversal.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d);
    int n;
    n = 0;
    case (op)
      2'b00: begin
        n = 32;
        for (int i = 0; i < 32; i++) if (d[i]) n = 31 - i;
      end
      2'b01: begin
        n = 32;
        for (int i = 31; i >= 0; i--) if (d[i]) n = i;
      end
      2'b10: n = $countones(d);
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  // Scoreboard: push on accepted input, pop on delivered output, drop on flush/reset.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  out_data, prev_data);
        chk("hold_tag",   32'(out_tag), 32'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", out_data, e.dat);
          chk("sb_tag",  32'(out_tag), 32'(e.tag));
        end
      end
      if (flush) begin
        sb_q.delete();
        if (in_valid) chk("ready_in_flush", 32'(in_ready), 32'd0);
      end else if (in_valid && in_ready) begin
        e.dat = model(in_op, in_data);
        e.tag = in_tag;
        sb_q.push_back(e);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_tag   = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    tick();

    // CLZ of 0x00010000, tag 5: result 15 exactly two cycles later
    drive(1'b1, 2'b00, 32'h0001_0000, 7'd5);
    @(negedge clk); chk("clz_acc_ready", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("clz_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("clz_lat2_valid", 32'(out_valid), 32'd1);
    chk("clz_data", out_data, 32'd15);
    chk("clz_tag",  32'(out_tag), 32'd5);
    tick();

    // CTZ of 0 then 0x80000000 back to back
    drive(1'b1, 2'b01, 32'h0000_0000, 7'd1); tick();
    drive(1'b1, 2'b01, 32'h8000_0000, 7'd2); tick();
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("ctz0_valid", 32'(out_valid), 32'd1); chk("ctz0_data", out_data, 32'd32);
    tick();
    @(negedge clk); chk("ctz31_valid", 32'(out_valid), 32'd1); chk("ctz31_data", out_data, 32'd31);
    tick();

    // CPOP stream, then a reserved op
    drive(1'b1, 2'b10, 32'hFFFF_FFFF, 7'd3);
    @(negedge clk); chk("cpop_ready0", 32'(in_ready), 32'd1); tick();
    drive(1'b1, 2'b10, 32'h0000_0001, 7'd4);
    @(negedge clk); chk("cpop_ready1", 32'(in_ready), 32'd1); tick();
    drive(1'b1, 2'b10, 32'hA5A5_A5A5, 7'd6);
    @(negedge clk); chk("cpop_ready2", 32'(in_ready), 32'd1); chk("cpop_d32", out_data, 32'd32); tick();
    drive(1'b1, 2'b11, 32'h0000_FFFF, 7'd7);
    @(negedge clk); chk("rsv_ready", 32'(in_ready), 32'd1); chk("cpop_d1", out_data, 32'd1); tick();
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("cpop_d16", out_data, 32'd16); tick();
    @(negedge clk); chk("rsv_valid", 32'(out_valid), 32'd1); chk("rsv_data", out_data, 32'd0); tick();
    tick();

    // Backpressure: three offered with out_ready low, two accepted
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0001, 7'd10);
    @(negedge clk); chk("bp_ready_a", 32'(in_ready), 32'd1); tick();
    drive(1'b1, 2'b00, 32'h0000_00FF, 7'd11);
    @(negedge clk); chk("bp_ready_b", 32'(in_ready), 32'd1); tick();
    drive(1'b1, 2'b10, 32'h0000_0007, 7'd12);
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_full_data",  out_data, 32'd31);
    tick();
    @(negedge clk); chk("bp_hold_ready", 32'(in_ready), 32'd0); chk("bp_hold_tag", 32'(out_tag), 32'd10);
    tick();
    out_ready = 1'b1;
    @(negedge clk); chk("bp_release_ready", 32'(in_ready), 32'd1); chk("bp_r_d31", out_data, 32'd31);
    tick();
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("bp_r_d24", out_data, 32'd24); tick();
    @(negedge clk); chk("bp_r_d3", out_data, 32'd3); chk("bp_r_tag", 32'(out_tag), 32'd12); tick();
    tick();

    // Flush one cycle after accepting CLZ of 1; op offered during flush is dropped
    drive(1'b1, 2'b00, 32'h0000_0001, 7'd20); tick();
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'hFFFF_0000, 7'd30);
    @(negedge clk); chk("flush_ready", 32'(in_ready), 32'd0); tick();
    flush = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_0F0F, 7'd21);
    @(negedge clk); chk("post_flush_valid0", 32'(out_valid), 32'd0); chk("post_flush_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("post_flush_valid1", 32'(out_valid), 32'd0); tick();
    @(negedge clk);
    chk("post_flush_valid2", 32'(out_valid), 32'd1);
    chk("post_flush_data", out_data, 32'd8);
    chk("post_flush_tag",  32'(out_tag), 32'd21);
    tick(); tick();

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_0100, 7'd40); tick();
    drive(1'b1, 2'b00, 32'h0000_0100, 7'd41); tick();
    drive(1'b0, 2'b00, 32'd0, 7'd0);
    @(negedge clk); chk("pre_rst_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk("post_rst_valid", 32'(out_valid), 32'd0); chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("post_rst_quiet", 32'(out_valid), 32'd0);
      tick();
    end

    @(negedge clk); chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_unit.md
COUNT_UNIT -- requirements
Module: count_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 7, meaning the width of the opaque tag carried with each operation.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  kills all in-flight operations.
REQ-005 SHALL have port in_valid  input  1  an operation is offered.
REQ-006 SHALL have port in_ready  output  1  the unit accepts the offered operation this cycle.
REQ-007 SHALL have port in_op  input  2  operation code: 00 CLZ, 01 CTZ, 10 CPOP, 11 reserved.
REQ-008 SHALL have port in_data  input  32  source operand.
REQ-009 SHALL have port in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-010 SHALL have port out_valid  output  1  result presented.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-012 SHALL have port out_data  output  32  result, zero-extended to 32 bits.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the presented result.

Function
REQ-014 SHALL use a 2-stage pipeline: S1 is the operand register, S2 is the result register.
REQ-015 SHALL accept an operation on a cycle where in_valid and in_ready are both high and flush is low.
REQ-016 SHALL capture into S1 on acceptance: the operand bit-reversed for CTZ, the operand unchanged for CLZ and CPOP, plus op and tag.
REQ-017 SHALL compute in S2 from the S1 operand: for CLZ/CTZ, the leading-zero count (0..32, 32 when operand is zero); for CPOP, the population count (0..32); for op 11, 0.
REQ-018 SHALL drive out_data[5:0] with the count and out_data[31:6] with zero.
REQ-019 SHALL present a result with out_valid high exactly 2 cycles after acceptance when out_ready is held high.
REQ-020 SHALL sustain one accepted operation per cycle with out_ready high.
REQ-021 SHALL hold out_valid, out_data and out_tag stable while out_valid is high and out_ready is low.
REQ-022 SHALL advance S1 into S2 only when S2 is empty or S2 is handed off in the same cycle.
REQ-023 SHALL drive in_ready combinationally as: S1 empty, or S1 advancing this cycle (in_ready may depend on out_ready).
REQ-024 SHALL drive in_ready low while flush is high.
REQ-025 SHALL keep in_valid, in_op, in_data and in_tag free of any combinational path to out_*.
REQ-026 SHALL, when both stages are full and out_ready is low, hold both stages and drive in_ready low.
REQ-027 SHALL, on flush, clear both stage valid bits at the next edge; an in_valid offered in the flush cycle is discarded; a result handed off in the flush cycle still counts as delivered.
REQ-028 SHALL deliver results in acceptance order, with no duplication or loss except by flush or rst.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear the S1 and S2 valid bits; rst takes priority over flush and in_valid.
REQ-030 SHALL drive out_valid low and in_ready high in the first cycle after rst deasserts; out_data and out_tag are don't-care while out_valid is low.
REQ-031 SHALL discard, on rst asserted mid-operation, every in-flight operation, with no result appearing after rst.

Verification
REQ-032 Scenario: CLZ of 0x00010000, tag 5, out_ready=1 -> out_valid 2 cycles later with out_data=15, out_tag=5.
REQ-033 Scenario: CTZ of 0x00000000 and CTZ of 0x80000000 back to back -> results 32, then 31, on consecutive cycles.
REQ-034 Scenario: CPOP of 0xFFFFFFFF, 0x00000001 and 0xA5A5A5A5 streamed -> results 32, 1, 16 in order; in_ready stays 1 throughout.
REQ-035 Scenario: out_ready held 0 while 3 operations are offered -> 2 accepted; in_ready=0 from the cycle both stages are full; out_data held stable; after out_ready=1, all 3 results emerge in order.
REQ-036 Scenario: flush one cycle after accepting CLZ of 0x1 -> no out_valid for it; a new operation accepted the cycle after flush returns its correct result 2 cycles later.
REQ-037 Scenario: rst pulsed with both stages full -> out_valid=0 the cycle after rst deasserts, in_ready=1, and no stale results appear.
